// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 4-digit common-anode 7-segment scan driver
// Frame-latched digits, leading-zero blanking, decimal points, blink and freeze.
module seven_seg_scan_driver #(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] seg1,
  input  logic [3:0] seg2,
  input  logic [3:0] seg3,
  input  logic [3:0] seg4,
  input  logic       enable,
  input  logic       lzb,
  input  logic [3:0] dp_mask,
  input  logic       blink_en,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [6:0] seg_out,
  output logic       dp
);

  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);
  localparam logic [BFW-1:0] BF_LAST = BFW'(BLINK_FRAMES - 1);

  logic [PCW-1:0] pc;
  logic [1:0]     idx;
  logic [3:0]     shadow [4];
  logic [BFW-1:0] blink_cnt;
  logic           blink_on;

  logic       frame_end;
  logic       phase_on;
  logic       dark;
  logic [3:0] cur_digit;
  logic [3:0] next_an;
  logic [6:0] next_seg;
  logic       next_dp;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h40;
      4'd1:    encode = 7'h79;
      4'd2:    encode = 7'h24;
      4'd3:    encode = 7'h30;
      4'd4:    encode = 7'h19;
      4'd5:    encode = 7'h12;
      4'd6:    encode = 7'h02;
      4'd7:    encode = 7'h78;
      4'd8:    encode = 7'h00;
      4'd9:    encode = 7'h10;
      default: encode = 7'h3F;
    endcase
  endfunction

  assign frame_end = (pc == PC_LAST) && (idx == 2'd3);
  assign cur_digit = shadow[idx];
  // Dropping blink_en must relight on the very next cycle, so gate on it directly.
  assign phase_on  = !blink_en || blink_on;
  assign dark      = (pc == '0) || !enable || !phase_on ||
                     ((idx == 2'd0) && lzb && (shadow[0] == 4'd0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc        <= '0;
      idx       <= 2'd0;
      shadow[0] <= 4'd0;
      shadow[1] <= 4'd0;
      shadow[2] <= 4'd0;
      shadow[3] <= 4'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (pc == PC_LAST) begin
        pc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        pc <= pc + PCW'(1);
      end
      if (frame_end && !freeze) begin
        shadow[0] <= seg1;
        shadow[1] <= seg2;
        shadow[2] <= seg3;
        shadow[3] <= seg4;
      end
      if (!blink_en) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (frame_end) begin
        if (blink_cnt == BF_LAST) begin
          blink_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          blink_cnt <= blink_cnt + BFW'(1);
        end
      end
    end
  end

  always_comb begin
    next_an  = 4'hF;
    next_seg = 7'h7F;
    next_dp  = 1'b1;
    if (!dark) begin
      next_an[2'd3 - idx] = 1'b0;
      next_seg            = encode(cur_digit);
      next_dp             = ~dp_mask[2'd3 - idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an      <= 4'hF;
      seg_out <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      an      <= next_an;
      seg_out <= next_seg;
      dp      <= next_dp;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - randomized bench with cycle-count display model
// Model derives slot/digit from elapsed cycles and blink phase from frame counts.
module tb_seven_seg_scan_driver;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] seg1 = 4'd1, seg2 = 4'd2, seg3 = 4'd3, seg4 = 4'd4;
  logic       enable = 1'b1, lzb = 1'b0, blink_en = 1'b0, freeze = 1'b0;
  logic [3:0] dp_mask = 4'b0000;
  logic [3:0] an;
  logic [6:0] seg_out;
  logic       dp;

  seven_seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetn(resetn),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
    .enable(enable), .lzb(lzb), .dp_mask(dp_mask),
    .blink_en(blink_en), .freeze(freeze),
    .an(an), .seg_out(seg_out), .dp(dp)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_on = 1'b0;

  logic [6:0] enc_tab [16];
  initial begin
    enc_tab[0] = 7'h40; enc_tab[1] = 7'h79; enc_tab[2] = 7'h24; enc_tab[3] = 7'h30;
    enc_tab[4] = 7'h19; enc_tab[5] = 7'h12; enc_tab[6] = 7'h02; enc_tab[7] = 7'h78;
    enc_tab[8] = 7'h00; enc_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) enc_tab[i] = 7'h3F;
  end

  // Model state: cycles since reset release, latched digits, frame ends seen while blinking.
  int         k = 0;
  int         mk = -1;
  int         nb = 0;
  logic [3:0] sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k = 0; mk = -1; nb = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      int  p, d;
      bit  fe, lit, blank;
      p     = k % SD;
      d     = (k / SD) % 4;
      fe    = (p == SD - 1) && (d == 3);
      lit   = !blink_en || (((nb / BF) % 2) == 0);
      blank = (p == 0) || !enable || !lit || (d == 0 && lzb && sh[0] == 4'd0);
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (!blank) begin
        exp_an[3 - d] = 1'b0;
        exp_seg       = enc_tab[sh[d]];
        exp_dp        = !dp_mask[3 - d];
      end
      mk = k;
      if (fe && !freeze) begin
        sh[0] = seg1; sh[1] = seg2; sh[2] = seg3; sh[3] = seg4;
      end
      if (!blink_en) nb = 0;
      else if (fe) nb = nb + 1;
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      total_cnt++;
      if (an === exp_an && seg_out === exp_seg && dp === exp_dp)
        pass_cnt++;
      else
        $display("FAIL model k=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                 mk, an, seg_out, dp, exp_an, exp_seg, exp_dp);
    end
  end

  task automatic chk_lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic p);
    total_cnt++;
    if (an === a && seg_out === s && dp === p)
      pass_cnt++;
    else
      $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               name, an, seg_out, dp, a, s, p);
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mk != target && n < 500);
    if (mk != target) begin
      total_cnt++;
      $display("FAIL wait_k timeout: got k=%0d, want %0d", mk, target);
    end
  endtask

  task automatic wait_slot(input int d, input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mk >= 0 && mk % SD == p && (mk / SD) % 4 == d) && n < 500);
    if (n >= 500) begin
      total_cnt++;
      $display("FAIL wait_slot timeout: slot %0d/%0d never reached", d, p);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk_lit("reset_state", 4'hF, 7'h7F, 1'b1);
    resetn = 1'b1;

    wait_k(0);  chk_lit("guard_k0", 4'hF, 7'h7F, 1'b1);
    wait_k(1);  chk_lit("frame0_d1", 4'b0111, 7'h40, 1'b1);
    wait_k(17); chk_lit("frame1_d1", 4'b0111, 7'h79, 1'b1);
    seg2 = 4'd7;
    wait_k(21); chk_lit("frame1_d2_old", 4'b1011, 7'h24, 1'b1);
    wait_k(25); chk_lit("frame1_d3", 4'b1101, 7'h30, 1'b1);
    wait_k(29); chk_lit("frame1_d4", 4'b1110, 7'h19, 1'b1);
    wait_k(37); chk_lit("frame2_d2_new", 4'b1011, 7'h78, 1'b1);

    lzb = 1'b1; dp_mask = 4'b0100;
    seg1 = 4'd0; seg2 = 4'd5; seg3 = 4'hC; seg4 = 4'd9;
    wait_slot(3, 3);
    wait_slot(0, 1); chk_lit("lzb_dark", 4'hF, 7'h7F, 1'b1);
    wait_slot(1, 1); chk_lit("d2_dp", 4'b1011, 7'h12, 1'b0);
    wait_slot(2, 1); chk_lit("d3_dash", 4'b1101, 7'h3F, 1'b1);
    wait_slot(3, 1); chk_lit("d4_nodp", 4'b1110, 7'h10, 1'b1);

    lzb = 1'b0;
    blink_en = 1'b1;
    repeat (140) @(negedge clk);
    blink_en = 1'b0;
    repeat (20) @(negedge clk);

    freeze = 1'b1;
    seg1 = 4'd8; seg2 = 4'd6; seg3 = 4'd1; seg4 = 4'd2;
    repeat (3 * 4 * SD) @(negedge clk);
    freeze = 1'b0;
    repeat (2 * 4 * SD) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 8)  seg1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 8)  seg2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 8)  seg3 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 8)  seg4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3)  enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 3)  lzb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3)  dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) < 2) blink_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) < 3) freeze = 1'($urandom_range(0, 1));
      if (i % 16 == 15 && $urandom_range(0, 9) == 0) seg1 = 4'd0;
    end

    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_lit("async_reset", 4'hF, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    enable = 1'b1; blink_en = 1'b0; lzb = 1'b0; freeze = 1'b0; dp_mask = 4'b0000;
    resetn = 1'b1;
    wait_k(1); chk_lit("restart_d1_zero", 4'b0111, 7'h40, 1'b1);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
